de_stage_multi: RTL and testbench
=================================

Name: de_stage_multi

Overview:
Parametrised, multi-lane successor to the single-instruction decode stage. Accepts a bundle of LANES fetched RV32I instructions per cycle and decodes each lane fully: opcode class, register fields, sign-extended immediate, operand-use flags, illegal flag. Sits between fetch and register-read. Adds what the single-lane stage lacks: valid/ready backpressure with a skid buffer, pipeline flush, zeroed unused fields and illegal-instruction detection.

Parameters:
LANES, 2, instructions per bundle (1..4)
XLEN, 32, PC/immediate width
SKID, 1, 1 = two-entry output buffer (full throughput under backpressure); 0 = single register, in_rdy = out_rdy || !out_valid

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset (bool)
flush  in  1  drop all buffered and incoming bundles
in_valid  in  LANES  per-lane valid from fetch
in_pc  in  LANES*XLEN  per-lane PC
in_inst  in  LANES*32  per-lane instruction word
in_rdy  out  1  stage can accept a bundle this cycle
out_valid  out  LANES  per-lane valid to register-read
out_de  out  LANES*$bits(core::de_inst_t)  decoded lane fields
out_pc  out  LANES*XLEN  lane PC, passed through
out_inst  out  LANES*32  lane raw instruction, passed through
out_rdy  in  1  downstream accepts bundle

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high. At reset, out_valid=0, all out_* data=0, skid empty, in_rdy=1 on the first cycle after reset deasserts.
- Bundle valid = |in_valid. Accept (in_fire) = bundle valid && in_rdy. Emit (out_fire) = |out_valid && out_rdy. The whole bundle moves as a unit. Lane valid bits are preserved, with no compaction.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty.
- Buffer states (SKID=1):
  - EMPTY: in_fire moves to ONE.
  - ONE: in_fire with out_fire stays ONE (out reg reloaded). in_fire without out_fire moves to TWO (bundle goes to skid). out_fire without in_fire moves to EMPTY.
  - TWO: in_rdy=0. out_fire moves skid to the out reg and goes to ONE.
- in_rdy is registered: in_rdy = (state != TWO). It must not depend combinationally on out_rdy.
- Flush: synchronous. Next state is EMPTY, out_valid=0. A bundle presented in the same cycle is dropped. Flush has priority over in_fire and out_fire. Data registers may keep stale values, but out_valid must be 0.
- rst has priority over flush.
- Decode, per lane, combinational before the register:
  - opcode = inst[6:0].
  - Immediate formats: I, S, B, U, J, each sign-extended to XLEN. U = {inst[31:12],12'b0}.
  - has_rs1/has_rs2/has_rd per class:
    - lui/auipc/jal: 0/0/1
    - jalr/load/imm_op: 1/0/1
    - branch/store: 1/1/0
    - op: 1/1/1
    - sys/fence: 0/0/0
  - Fields a class does not use are driven 0 (rs1, rs2, rd, funct3, funct7, imm). No stale values.
  - has_rd forced to 0 when rd==0.
  - funct7 is kept for op, and for imm_op shifts (funct3 = 001/101).
- illegal = 1 when any of these hold: inst[1:0] != 2'b11; unknown opcode; op with funct7 not in {0x00, 0x20}; a lane with in_valid=0 never raises illegal. When illegal=1, has_* = 0 and all fields are 0.
- A lane with in_valid=0 inside a valid bundle produces out_valid[lane]=0 and all-zero decode.

Decomposition:
- core package gains:
  - de_inst_t (opcode, funct3, funct7, rs1, rs2, rd, imm, has_rs1, has_rs2, has_rd, illegal)
  - de_inst_rst
  - opcode class enum
- Immediate extractors get_imm_i/s/b/u/j move into the rv32i package alongside the get_* field functions.
- One sub-module: de_lane_decode, purely combinational, one 32-bit instruction in, one de_inst_t out, instantiated LANES times via generate.
- The skid/state logic stays in de_stage_multi.

Test Plan:
- LANES=2. Lane0 0x00500093 (addi x1,x0,5), lane1 0x12345137 (lui x2,0x12345), out_rdy=1 -> next cycle out_valid=2'b11; lane0 rd=1, imm=5, has_rs1=1, has_rs2=0, has_rd=1; lane1 rd=2, imm=0x12345000, rs1=0.
- Lane0 0xFE208EE3 (beq x1,x2,-4), lane1 in_valid=0 -> out_valid=2'b01; lane0 imm=0xFFFFFFFC, rs1=1, rs2=2, has_rd=0, rd=0; lane1 decode all 0.
- Lane0 0x00000000, lane1 0x00000013 (nop, addi x0,x0,0) -> lane0 illegal=1 with all has_*=0; lane1 illegal=0, has_rd=0 because rd==0.
- Backpressure: stream bundles A,B,C with out_rdy=0 -> A held on out_*, B in skid, in_rdy=0 after B, C held at input. Raise out_rdy -> A, B, C emitted in order on consecutive cycles, none lost or duplicated.
- Flush in state TWO, with a bundle also presented that cycle -> next cycle out_valid=0, in_rdy=1; the presented bundle is never emitted.
- rst asserted mid-stream for 1 cycle (sampled at the edge only) -> out_valid=0, outputs 0, in_rdy=1 the following cycle; with SKID=0 repeat the backpressure test and confirm in_rdy=0 while out_valid && !out_rdy.

Source files
------------

// File: rtl/de_stage_multi_pkg.sv
// ---------------------------------------------------------------------------
// de_stage_multi_pkg
// Shared types and helpers for the multi-lane RV32I decode stage.
//   - de_inst_t     : decoded per-lane record carried to register-read
//   - de_inst_rst   : all-zero value of de_inst_t (reset / unused lanes)
//   - op_class_e    : opcode class produced by the first decode step
//   - buf_state_e   : occupancy of the output buffer in the stage
//   - get_*         : raw field and immediate extractors for a 32-bit word
// No ports; imported by de_lane_decode and de_stage_multi.
// ---------------------------------------------------------------------------
package de_stage_multi_pkg;

    localparam int ILEN  = 32;
    localparam int IMM_W = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_IMM,
        CLS_OP,
        CLS_FENCE,
        CLS_SYS,
        CLS_BAD
    } op_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } buf_state_e;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [IMM_W-1:0] imm;
        logic             has_rs1;
        logic             has_rs2;
        logic             has_rd;
        logic             illegal;
    } de_inst_t;

    localparam de_inst_t de_inst_rst = '0;
    localparam int       DE_W        = $bits(de_inst_t);

    function automatic logic [6:0] get_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    function automatic logic [2:0] get_funct3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

    function automatic logic [6:0] get_funct7(input logic [31:0] inst);
        return inst[31:25];
    endfunction

    function automatic logic [IMM_W-1:0] get_imm_i(input logic [31:0] inst);
        return {{(IMM_W-12){inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [IMM_W-1:0] get_imm_s(input logic [31:0] inst);
        return {{(IMM_W-12){inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [IMM_W-1:0] get_imm_b(input logic [31:0] inst);
        return {{(IMM_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [IMM_W-1:0] get_imm_u(input logic [31:0] inst);
        return {{(IMM_W-32){inst[31]}}, inst[31:12], 12'b0};
    endfunction

    function automatic logic [IMM_W-1:0] get_imm_j(input logic [31:0] inst);
        return {{(IMM_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Anything without the 32-bit encoding marker in [1:0] is treated as
    // an unknown opcode, so compressed encodings land in CLS_BAD too.
    function automatic op_class_e get_class(input logic [31:0] inst);
        op_class_e cls;
        cls = CLS_BAD;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                OPC_LUI:    cls = CLS_LUI;
                OPC_AUIPC:  cls = CLS_AUIPC;
                OPC_JAL:    cls = CLS_JAL;
                OPC_JALR:   cls = CLS_JALR;
                OPC_BRANCH: cls = CLS_BRANCH;
                OPC_LOAD:   cls = CLS_LOAD;
                OPC_STORE:  cls = CLS_STORE;
                OPC_IMM:    cls = CLS_IMM;
                OPC_OP:     cls = CLS_OP;
                OPC_FENCE:  cls = CLS_FENCE;
                OPC_SYS:    cls = CLS_SYS;
                default:    cls = CLS_BAD;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/de_lane_decode.sv
// ---------------------------------------------------------------------------
// de_lane_decode
// Purely combinational decode of one RV32I instruction word.
// Ports:
//   inst  in  32       raw instruction word
//   de    out de_inst_t decoded fields; unused fields are zero, illegal
//                       encodings produce illegal=1 with everything else 0
// ---------------------------------------------------------------------------
module de_lane_decode
    import de_stage_multi_pkg::*;
(
    input  logic [31:0] inst,
    output de_inst_t    de
);

    op_class_e        cls;
    logic             use_rs1;
    logic             use_rs2;
    logic             use_rd;
    logic             use_f3;
    logic             use_f7;
    logic             bad;
    logic [IMM_W-1:0] imm;

    // Classify the word and decide which fields this class actually uses.
    // funct3 is kept for every class that carries one (everything except
    // lui/auipc/jal); funct7 only for register ops and immediate shifts.
    always_comb begin
        cls     = get_class(inst);
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        use_f3  = 1'b0;
        use_f7  = 1'b0;
        bad     = 1'b0;
        imm     = '0;
        case (cls)
            CLS_LUI, CLS_AUIPC: begin
                use_rd = 1'b1;
                imm    = get_imm_u(inst);
            end
            CLS_JAL: begin
                use_rd = 1'b1;
                imm    = get_imm_j(inst);
            end
            CLS_JALR, CLS_LOAD: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                use_f3  = 1'b1;
                imm     = get_imm_i(inst);
            end
            CLS_IMM: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                use_f3  = 1'b1;
                use_f7  = (get_funct3(inst) == 3'b001) || (get_funct3(inst) == 3'b101);
                imm     = get_imm_i(inst);
            end
            CLS_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                imm     = get_imm_b(inst);
            end
            CLS_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                imm     = get_imm_s(inst);
            end
            CLS_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                use_f3  = 1'b1;
                use_f7  = 1'b1;
                bad     = (get_funct7(inst) != 7'h00) && (get_funct7(inst) != 7'h20);
            end
            CLS_FENCE, CLS_SYS: begin
                use_f3 = 1'b1;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    // Assemble the record. Unused fields are forced to zero so nothing
    // stale from the raw word leaks downstream; writing x0 is not a write.
    always_comb begin
        de = de_inst_rst;
        if (bad) begin
            de.illegal = 1'b1;
        end else begin
            de.opcode  = get_opcode(inst);
            de.funct3  = use_f3  ? get_funct3(inst) : 3'b0;
            de.funct7  = use_f7  ? get_funct7(inst) : 7'b0;
            de.rs1     = use_rs1 ? get_rs1(inst)    : 5'b0;
            de.rs2     = use_rs2 ? get_rs2(inst)    : 5'b0;
            de.rd      = use_rd  ? get_rd(inst)     : 5'b0;
            de.imm     = imm;
            de.has_rs1 = use_rs1;
            de.has_rs2 = use_rs2;
            de.has_rd  = use_rd && (get_rd(inst) != 5'd0);
        end
    end

endmodule

// File: rtl/de_stage_multi.sv
// ---------------------------------------------------------------------------
// de_stage_multi
// Multi-lane decode stage between fetch and register-read. Each lane is
// decoded combinationally, then the whole bundle is registered behind a
// valid/ready handshake with an optional skid entry.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flush        drop buffered bundles and the bundle presented this cycle
//   in_valid     per-lane valid from fetch (bundle valid = OR of lanes)
//   in_pc        per-lane PC, LANES*XLEN
//   in_inst      per-lane instruction word, LANES*32
//   in_rdy       stage can take a bundle this cycle
//   out_valid    per-lane valid to register-read
//   out_de       per-lane de_inst_t, LANES*DE_W
//   out_pc       per-lane PC passed through
//   out_inst     per-lane instruction passed through
//   out_rdy      downstream takes the bundle this cycle
// Parameters: LANES (1..4), XLEN, SKID (1 = two entries, 0 = one entry).
// ---------------------------------------------------------------------------
module de_stage_multi
    import de_stage_multi_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int SKID  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [LANES-1:0]      in_valid,
    input  logic [LANES*XLEN-1:0] in_pc,
    input  logic [LANES*32-1:0]   in_inst,
    output logic                  in_rdy,
    output logic [LANES-1:0]      out_valid,
    output logic [LANES*DE_W-1:0] out_de,
    output logic [LANES*XLEN-1:0] out_pc,
    output logic [LANES*32-1:0]   out_inst,
    input  logic                  out_rdy
);

    logic [LANES*DE_W-1:0] dec_de;

    // Invalid lanes inside a valid bundle carry an all-zero record, which
    // also keeps them from ever reporting illegal.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        de_inst_t lane_de;

        de_lane_decode u_dec (
            .inst (in_inst[g*32 +: 32]),
            .de   (lane_de)
        );

        assign dec_de[g*DE_W +: DE_W] = in_valid[g] ? lane_de : de_inst_rst;
    end

    buf_state_e state;
    buf_state_e state_nxt;

    logic in_fire;
    logic out_fire;
    logic load_in;
    logic load_skid;
    logic load_from_skid;
    logic drain;

    logic [LANES-1:0]      skid_valid;
    logic [LANES*DE_W-1:0] skid_de;
    logic [LANES*XLEN-1:0] skid_pc;
    logic [LANES*32-1:0]   skid_inst;

    assign in_fire  = (|in_valid) && in_rdy;
    assign out_fire = (|out_valid) && out_rdy;

    // State register for buffer occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy transitions. Flush wins over both handshakes. With SKID=0
    // an accept in ONE always coincides with an emit, so TWO is unreachable.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) state_nxt = ST_ONE;
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_nxt = (SKID != 0) ? ST_TWO : ST_ONE;
                    end else if (out_fire && !in_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) state_nxt = ST_ONE;
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake and datapath steering. With the skid entry, in_rdy comes
    // straight from the state flops so it never sees out_rdy; without it
    // the single register can refill in the same cycle it drains.
    always_comb begin
        in_rdy         = 1'b1;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        drain          = 1'b0;
        if (SKID != 0) begin
            in_rdy = (state != ST_TWO);
        end else begin
            in_rdy = out_rdy || !(|out_valid);
        end
        if (!flush) begin
            case (state)
                ST_EMPTY: begin
                    load_in = in_fire;
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid = (SKID != 0);
                    end else if (out_fire) begin
                        drain = 1'b1;
                    end
                end
                ST_TWO: begin
                    load_from_skid = out_fire;
                end
                default: begin
                    load_in = 1'b0;
                end
            endcase
        end
    end

    // Output register. Flush only clears valid; data may stay stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_de    <= '0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else if (flush) begin
            out_valid <= '0;
        end else if (load_in) begin
            out_valid <= in_valid;
            out_de    <= dec_de;
            out_pc    <= in_pc;
            out_inst  <= in_inst;
        end else if (load_from_skid) begin
            out_valid <= skid_valid;
            out_de    <= skid_de;
            out_pc    <= skid_pc;
            out_inst  <= skid_inst;
        end else if (drain) begin
            out_valid <= '0;
        end
    end

    // Skid entry catches the bundle accepted while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= '0;
            skid_de    <= '0;
            skid_pc    <= '0;
            skid_inst  <= '0;
        end else if (load_skid) begin
            skid_valid <= in_valid;
            skid_de    <= dec_de;
            skid_pc    <= in_pc;
            skid_inst  <= in_inst;
        end
    end

endmodule

// File: tb/tb_de_stage_multi.sv
// ---------------------------------------------------------------------------
// tb_de_stage_multi
// Self-checking bench for de_stage_multi: a decode vector table run with
// out_rdy=1, then hand sequences for backpressure, flush, mid-stream reset
// and the single-register (SKID=0) variant.
// ---------------------------------------------------------------------------
module tb_de_stage_multi;
    import de_stage_multi_pkg::*;

    localparam int LANES = 2;
    localparam int XLEN  = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [LANES-1:0]      in_valid;
    logic [LANES*XLEN-1:0] in_pc;
    logic [LANES*32-1:0]   in_inst;
    logic                  out_rdy;

    logic                  s1_in_rdy;
    logic [LANES-1:0]      s1_out_valid;
    logic [LANES*DE_W-1:0] s1_out_de;
    logic [LANES*XLEN-1:0] s1_out_pc;
    logic [LANES*32-1:0]   s1_out_inst;

    logic                  s0_in_rdy;
    logic [LANES-1:0]      s0_out_valid;
    logic [LANES*DE_W-1:0] s0_out_de;
    logic [LANES*XLEN-1:0] s0_out_pc;
    logic [LANES*32-1:0]   s0_out_inst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    de_stage_multi #(.LANES(LANES), .XLEN(XLEN), .SKID(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_rdy    (s1_in_rdy),
        .out_valid (s1_out_valid),
        .out_de    (s1_out_de),
        .out_pc    (s1_out_pc),
        .out_inst  (s1_out_inst),
        .out_rdy   (out_rdy)
    );

    de_stage_multi #(.LANES(LANES), .XLEN(XLEN), .SKID(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_rdy    (s0_in_rdy),
        .out_valid (s0_out_valid),
        .out_de    (s0_out_de),
        .out_pc    (s0_out_pc),
        .out_inst  (s0_out_inst),
        .out_rdy   (out_rdy)
    );

    typedef struct {
        logic [1:0]  v;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  ov;
        de_inst_t    e0;
        de_inst_t    e1;
    } vec_t;

    vec_t vecs[9];

    function automatic de_inst_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [4:0] rd,
                                    input logic [31:0] imm, input logic h1,
                                    input logic h2, input logic hd, input logic ill);
        de_inst_t d;
        d.opcode  = opc;
        d.funct3  = f3;
        d.funct7  = f7;
        d.rs1     = rs1;
        d.rs2     = rs2;
        d.rd      = rd;
        d.imm     = imm;
        d.has_rs1 = h1;
        d.has_rs2 = h2;
        d.has_rd  = hd;
        d.illegal = ill;
        return d;
    endfunction

    function automatic de_inst_t s1_lane(input int i);
        return de_inst_t'(s1_out_de[i*DE_W +: DE_W]);
    endfunction

    function automatic logic [31:0] s1_pc(input int i);
        return s1_out_pc[i*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] s0_pc(input int i);
        return s0_out_pc[i*XLEN +: XLEN];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0,
                                 input logic [31:0] i1, input logic [31:0] pc0);
        in_valid = v;
        in_inst  = {i1, i0};
        in_pc    = {pc0 + 32'd4, pc0};
    endtask

    task automatic idleInputs();
        in_valid = '0;
        in_inst  = '0;
        in_pc    = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    de_inst_t ill_de;
    de_inst_t zero_de;

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        out_rdy  = 1'b1;
        idleInputs();
        ill_de  = mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        zero_de = de_inst_rst;

        vecs[0] = '{2'b11, 32'h00500093, 32'h12345137, 2'b11,
                    mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00000005, 1'b1, 1'b0, 1'b1, 1'b0),
                    mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'h12345000, 1'b0, 1'b0, 1'b1, 1'b0)};
        vecs[1] = '{2'b01, 32'hFE208EE3, 32'h12345137, 2'b01,
                    mk(7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0),
                    zero_de};
        vecs[2] = '{2'b11, 32'h00000000, 32'h00000013, 2'b11,
                    ill_de,
                    mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0)};
        vecs[3] = '{2'b11, 32'h0020A423, 32'h402081B3, 2'b11,
                    mk(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'h00000008, 1'b1, 1'b1, 1'b0, 1'b0),
                    mk(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0)};
        vecs[4] = '{2'b11, 32'h022081B3, 32'h008000EF, 2'b11,
                    ill_de,
                    mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00000008, 1'b0, 1'b0, 1'b1, 1'b0)};
        vecs[5] = '{2'b11, 32'h40335293, 32'hFFC0A203, 2'b11,
                    mk(7'h13, 3'd5, 7'h20, 5'd6, 5'd0, 5'd5, 32'h00000403, 1'b1, 1'b0, 1'b1, 1'b0),
                    mk(7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd4, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1, 1'b0)};
        vecs[6] = '{2'b11, 32'hFFFFF397, 32'h00000073, 2'b11,
                    mk(7'h17, 3'd0, 7'h00, 5'd0, 5'd0, 5'd7, 32'hFFFFF000, 1'b0, 1'b0, 1'b1, 1'b0),
                    mk(7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[7] = '{2'b10, 32'h00500092, 32'h00500092, 2'b10,
                    zero_de,
                    ill_de};
        vecs[8] = '{2'b11, 32'hFFF00093, 32'h0000000F, 2'b11,
                    mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0),
                    mk(7'h0F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0)};

        // Reset state, first cycle after release.
        step();
        step();
        rst = 1'b0;
        step();
        checkOutput("reset out_valid", 128'(s1_out_valid), 128'(2'b00));
        checkOutput("reset out_de",    128'(s1_out_de),    128'(0));
        checkOutput("reset out_pc",    128'(s1_out_pc),    128'(0));
        checkOutput("reset out_inst",  128'(s1_out_inst),  128'(0));
        checkOutput("reset in_rdy",    128'(s1_in_rdy),    128'(1'b1));

        // Decode table, streamed with out_rdy=1: one cycle latency each.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k].v, vecs[k].i0, vecs[k].i1, 32'h1000 + 32'(k) * 32'h10);
            step();
            idleInputs();
            checkOutput($sformatf("vec%0d out_valid", k), 128'(s1_out_valid), 128'(vecs[k].ov));
            checkOutput($sformatf("vec%0d lane0 de", k),  128'(s1_lane(0)),   128'(vecs[k].e0));
            checkOutput($sformatf("vec%0d lane1 de", k),  128'(s1_lane(1)),   128'(vecs[k].e1));
            checkOutput($sformatf("vec%0d s0 out_valid", k), 128'(s0_out_valid), 128'(vecs[k].ov));
        end
        checkOutput("vec8 lane1 pc",   128'(s1_pc(1)), 128'(32'h1084));
        checkOutput("vec8 lane0 inst", 128'(s1_out_inst[31:0]), 128'(32'hFFF00093));
        step();
        checkOutput("table drained", 128'(s1_out_valid), 128'(2'b00));

        // Backpressure: A held, B in skid, C waits at the input.
        doReset();
        out_rdy = 1'b0;
        applyStimulus(2'b11, 32'h00500093, 32'h12345137, 32'h100);
        step();
        checkOutput("bp A out_valid", 128'(s1_out_valid), 128'(2'b11));
        checkOutput("bp A pc",        128'(s1_pc(0)),     128'(32'h100));
        checkOutput("bp in_rdy ONE",  128'(s1_in_rdy),    128'(1'b1));
        applyStimulus(2'b01, 32'h00000013, 32'h00000013, 32'h200);
        step();
        checkOutput("bp A held",      128'(s1_pc(0)),     128'(32'h100));
        checkOutput("bp in_rdy TWO",  128'(s1_in_rdy),    128'(1'b0));
        applyStimulus(2'b10, 32'h00000013, 32'h00000013, 32'h300);
        step();
        checkOutput("bp A still held", 128'(s1_pc(0)),    128'(32'h100));
        checkOutput("bp C blocked",    128'(s1_in_rdy),   128'(1'b0));
        out_rdy = 1'b1;
        step();
        checkOutput("bp B out_valid", 128'(s1_out_valid), 128'(2'b01));
        checkOutput("bp B pc",        128'(s1_pc(0)),     128'(32'h200));
        checkOutput("bp in_rdy back", 128'(s1_in_rdy),    128'(1'b1));
        step();
        idleInputs();
        checkOutput("bp C out_valid", 128'(s1_out_valid), 128'(2'b10));
        checkOutput("bp C pc",        128'(s1_pc(0)),     128'(32'h300));
        step();
        checkOutput("bp no duplicate", 128'(s1_out_valid), 128'(2'b00));

        // Flush while full, with a bundle presented in the same cycle.
        doReset();
        out_rdy = 1'b0;
        applyStimulus(2'b11, 32'h00500093, 32'h00500093, 32'h100);
        step();
        applyStimulus(2'b11, 32'h00500093, 32'h00500093, 32'h200);
        step();
        checkOutput("flush pre in_rdy", 128'(s1_in_rdy), 128'(1'b0));
        applyStimulus(2'b11, 32'h00500093, 32'h00500093, 32'h400);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idleInputs();
        checkOutput("flush out_valid", 128'(s1_out_valid), 128'(2'b00));
        checkOutput("flush in_rdy",    128'(s1_in_rdy),    128'(1'b1));
        out_rdy = 1'b1;
        step();
        checkOutput("flush nothing emitted", 128'(s1_out_valid), 128'(2'b00));

        // One-cycle reset in the middle of a stalled stream.
        out_rdy = 1'b0;
        applyStimulus(2'b11, 32'h00500093, 32'h12345137, 32'h500);
        step();
        applyStimulus(2'b11, 32'h00500093, 32'h12345137, 32'h600);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idleInputs();
        checkOutput("midrst out_valid", 128'(s1_out_valid), 128'(2'b00));
        checkOutput("midrst out_de",    128'(s1_out_de),    128'(0));
        checkOutput("midrst out_pc",    128'(s1_out_pc),    128'(0));
        checkOutput("midrst out_inst",  128'(s1_out_inst),  128'(0));
        checkOutput("midrst in_rdy",    128'(s1_in_rdy),    128'(1'b1));
        out_rdy = 1'b1;
        step();
        checkOutput("midrst skid empty", 128'(s1_out_valid), 128'(2'b00));

        // Single-register variant under backpressure.
        doReset();
        out_rdy = 1'b0;
        applyStimulus(2'b11, 32'h00500093, 32'h12345137, 32'h700);
        step();
        checkOutput("s0 A out_valid",   128'(s0_out_valid), 128'(2'b11));
        checkOutput("s0 in_rdy stall",  128'(s0_in_rdy),    128'(1'b0));
        applyStimulus(2'b01, 32'h00000013, 32'h00000013, 32'h800);
        step();
        checkOutput("s0 A held",        128'(s0_pc(0)),     128'(32'h700));
        checkOutput("s0 in_rdy held",   128'(s0_in_rdy),    128'(1'b0));
        out_rdy = 1'b1;
        #1;
        checkOutput("s0 in_rdy on out_rdy", 128'(s0_in_rdy), 128'(1'b1));
        step();
        idleInputs();
        checkOutput("s0 B out_valid",   128'(s0_out_valid), 128'(2'b01));
        checkOutput("s0 B pc",          128'(s0_pc(0)),     128'(32'h800));
        step();
        checkOutput("s0 drained",       128'(s0_out_valid), 128'(2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
